// File: rtl/matrix_mem_responder.sv
// ----------------------------------------------------------------------------
// matrix_mem_responder
//
// Memory-side responder for the coprocessor EXECUTE-stage start/wr/done
// handshake. Holds the matrix elements in an internal synchronous RAM and
// performs exactly one READ or WRITE per start assertion. Completion is a
// single-cycle done pulse; read data and the out-of-range error flag are held
// until the next completion.
//
// Handshake: the initiator raises start (a level) together with wr, address
// and wdata, and keeps start high until it sees done. The request fields are
// captured on the accepting edge only. done is high for exactly one cycle.
// A start that is still high after done parks the FSM in HOLD until it is
// released, so a held start can never launch a second operation. Dropping
// start before done does not cancel the operation.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        request level
//   wr         in   1        1 = WRITE, 0 = READ (sampled with start)
//   address    in   ADDR_W   element address (sampled with start)
//   wdata      in   DATA_W   write data (sampled with start)
//   done       out  1        one-cycle completion pulse
//   rdata      out  DATA_W   last read result, held until the next read completes
//   err        out  1        last completion was out of range, held until next done
//   busy       out  1        FSM is not in IDLE
//   op_count   out  16       completed requests, wraps modulo 2^16
//   state_dbg  out  3        current FSM state for observation
//
// READ_LAT must be in 1..3.
// ----------------------------------------------------------------------------
module matrix_mem_responder #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 25,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [15:0]       op_count,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RWAIT  = 3'd2,
        DONE   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields captured on the accepting edge
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Remaining RWAIT edges before the RAM output is taken
    logic [1:0]        wait_cnt;

    logic              in_range;
    logic              mem_we;
    logic              rd_en;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe [READ_LAT];

    // Unsigned compare; addresses at or beyond DEPTH never alias into the array
    assign in_range = ({{(32-ADDR_W){1'b0}}, addr_q} < 32'(DEPTH));
    assign mem_we   = (state == ACCESS) && wr_q && in_range;
    assign rd_en    = (state == ACCESS) || (state == RWAIT);

    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!wr_q && in_range) begin
                    state_next = RWAIT;
                end else begin
                    state_next = DONE;
                end
            end
            RWAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? HOLD : IDLE;
            end
            HOLD: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, result registers and completion counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= 2'd0;
            rdata    <= '0;
            err      <= 1'b0;
            op_count <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        wr_q    <= wr;
                        addr_q  <= address;
                        wdata_q <= wdata;
                    end
                end
                ACCESS: begin
                    if (!in_range) begin
                        err <= 1'b1;
                        if (!wr_q) begin
                            rdata <= '0;
                        end
                    end else if (wr_q) begin
                        err <= 1'b0;
                    end else begin
                        wait_cnt <= 2'(READ_LAT - 1);
                    end
                end
                RWAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rdata <= rd_pipe[READ_LAT-1];
                        err   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    op_count <= op_count + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Matrix storage: not reset, contents survive rst_n.
    // The write happens on the ACCESS edge only, so a reset that arrives
    // earlier abandons the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Read path: stage 0 samples the array on the ACCESS edge, the remaining
    // stages model the extra RAM latency. addr_q is stable and no write can
    // occur while a read is in flight, so the last stage holds the element
    // on the edge where the RWAIT countdown reaches zero.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_pipe[0] <= (in_range) ? mem[addr_q] : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

endmodule
